// File: rtl/roubus_wr_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | roubus_wr_arb_if : requester/FIFO-write bundle of the roubus arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface roubus_wr_arb_if #(
  parameter int WID = 32
);
  logic [3:0]       req;
  logic [4*WID-1:0] data;
  logic [3:0]       last;
  logic [3:0]       ack;
  logic             writex;
  logic             wfull;
  logic [WID+1:0]   wdata;
  logic             busy;
  logic [1:0]       gnt_id;
  logic             burst_cut;

  modport master (
    output req, data, last, wfull,
    input  ack, writex, wdata, busy, gnt_id, burst_cut
  );

  modport slave (
    input  req, data, last, wfull,
    output ack, writex, wdata, busy, gnt_id, burst_cut
  );
endinterface
`default_nettype wire

// File: rtl/roubus_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | roubus_wr_arb : 4-way round-robin burst arbiter for the FIFO write   |
// | port; tags each word with its 2-bit source id.  Rev 1.0              |
// +----------------------------------------------------------------------+
module roubus_wr_arb #(
  parameter int WID      = 32,
  parameter int MAXBURST = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  roubus_wr_arb_if.slave  bus
);

  localparam int         c_cnt_w = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_burst = 1'b1;

  logic [0:0]         r_state;
  logic [1:0]         r_rr_ptr;
  logic [1:0]         r_gnt_id;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_burst_cut;

  logic [WID-1:0]     w_slice [4];
  logic [1:0]         w_choice;
  logic [1:0]         w_idx;
  logic               w_found;
  logic               w_writex;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    assign w_slice[gi] = bus.data[gi*WID +: WID];
  end

  // First requesting bit at or after the round-robin pointer, wrapping mod 4.
  always_comb begin
    w_choice = r_rr_ptr;
    w_found  = 1'b0;
    w_idx    = r_rr_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_choice = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_writex      = (r_state == c_burst) && bus.req[r_gnt_id] && !bus.wfull;
  assign bus.writex    = w_writex;
  assign bus.ack       = w_writex ? (4'b0001 << r_gnt_id) : 4'b0000;
  assign bus.wdata     = {r_gnt_id, w_slice[r_gnt_id]};
  assign bus.busy      = (r_state == c_burst);
  assign bus.gnt_id    = r_gnt_id;
  assign bus.burst_cut = r_burst_cut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_rr_ptr    <= 2'd0;
      r_gnt_id    <= 2'd0;
      r_cnt       <= '0;
      r_burst_cut <= 1'b0;
    end else begin
      r_burst_cut <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_found) begin
            r_gnt_id <= w_choice;
            r_cnt    <= '0;
            r_state  <= c_burst;
          end
        end
        default: begin
          if (w_writex) begin
            r_cnt <= r_cnt + 1'b1;
            // A genuine last takes precedence over the forced release.
            if (bus.last[r_gnt_id]) begin
              r_state  <= c_idle;
              r_rr_ptr <= r_gnt_id + 2'd1;
            end else if (r_cnt == c_cnt_w'(MAXBURST - 1)) begin
              r_state     <= c_idle;
              r_rr_ptr    <= r_gnt_id + 2'd1;
              r_burst_cut <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_roubus_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_roubus_wr_arb : directed self-checking bench for roubus_wr_arb    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_roubus_wr_arb;

  localparam int WID      = 32;
  localparam int MAXBURST = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  roubus_wr_arb_if #(.WID(WID)) bus ();

  roubus_wr_arb #(.WID(WID), .MAXBURST(MAXBURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WID-1:0] pl(input int id, input int n);
    return 32'hC0DE_0000 | (id << 12) | n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req   = 4'b0000;
    bus.last  = 4'b0000;
    bus.wfull = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Drive word n of requester id, then check it is transferred this cycle.
  task automatic word(input string tag, input int id, input int n);
    bus.data[id*WID +: WID] = pl(id, n);
    #1;
    check({tag, "_wx"}, 64'(bus.writex), 64'd1);
    check({tag, "_ack"}, 64'(bus.ack), 64'(4'b0001 << id));
    check({tag, "_wd"}, 64'(bus.wdata), {30'd0, 2'(id), pl(id, n)});
    step();
  endtask

  task automatic idle_cycle(input string tag);
    #1;
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_wx"}, 64'(bus.writex), 64'd0);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.data = '0;
    for (int i = 0; i < 4; i++) bus.data[i*WID +: WID] = pl(i, 0);

    // Reset values
    do_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_wx", 64'(bus.writex), 64'd0);
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_gnt", 64'(bus.gnt_id), 64'd0);
    check("rst_cut", 64'(bus.burst_cut), 64'd0);
    check("rst_wd", 64'(bus.wdata), {30'd0, 2'd0, pl(0, 0)});
    step();
    do_reset();

    // 3-word burst from requester 0
    bus.req = 4'b0001;
    idle_cycle("t1_idle");
    for (int n = 1; n <= 3; n++) begin
      bus.last = (n == 3) ? 4'b0001 : 4'b0000;
      word("t1_w", 0, n);
    end
    bus.req  = 4'b0000;
    bus.last = 4'b0000;
    #1;
    check("t1_busy_end", 64'(bus.busy), 64'd0);

    // All four request, single-word bursts: 0,1,2,3,0
    do_reset();
    bus.req  = 4'b1111;
    bus.last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      idle_cycle("t2_idle");
      #1;
      check("t2_gnt", 64'(bus.gnt_id), 64'(k % 4));
      word("t2_w", k % 4, k + 1);
    end

    // Requester 2 streams without last; forced cut at MAXBURST
    do_reset();
    bus.req  = 4'b0100;
    bus.last = 4'b0000;
    idle_cycle("t3_idle");
    bus.req = 4'b0110;
    for (int n = 1; n <= MAXBURST; n++) word("t3_w", 2, n);
    #1;
    check("t3_cut", 64'(bus.burst_cut), 64'd1);
    check("t3_busy", 64'(bus.busy), 64'd0);
    bus.last = 4'b0010;
    step();
    check("t3_cut_pulse", 64'(bus.burst_cut), 64'd0);
    check("t3_gnt1", 64'(bus.gnt_id), 64'd1);
    word("t3_r1", 1, 1);
    idle_cycle("t3_idle2");
    check("t3_gnt2", 64'(bus.gnt_id), 64'd2);
    word("t3_r2", 2, 17);

    // wfull stall mid-burst; cnt must freeze
    do_reset();
    bus.req  = 4'b0001;
    bus.last = 4'b0000;
    idle_cycle("t4_idle");
    for (int n = 1; n <= 3; n++) word("t4_w", 0, n);
    bus.wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("t4_stall_wx", 64'(bus.writex), 64'd0);
      check("t4_stall_ack", 64'(bus.ack), 64'd0);
      check("t4_stall_busy", 64'(bus.busy), 64'd1);
      step();
    end
    bus.wfull = 1'b0;
    for (int n = 4; n <= MAXBURST; n++) word("t4_w", 0, n);
    #1;
    check("t4_cut", 64'(bus.burst_cut), 64'd1);

    // last on word MAXBURST wins over the cut
    do_reset();
    bus.req  = 4'b0011;
    bus.last = 4'b0000;
    idle_cycle("t5_idle");
    for (int n = 1; n <= MAXBURST; n++) begin
      bus.last = (n == MAXBURST) ? 4'b0001 : 4'b0000;
      word("t5_w", 0, n);
    end
    bus.last = 4'b0000;
    #1;
    check("t5_cut", 64'(bus.burst_cut), 64'd0);
    check("t5_busy", 64'(bus.busy), 64'd0);
    step();
    check("t5_gnt", 64'(bus.gnt_id), 64'd1);
    word("t5_r1", 1, 1);

    // Async reset mid-burst of requester 3
    do_reset();
    bus.req  = 4'b1000;
    bus.last = 4'b0000;
    idle_cycle("t6_idle");
    word("t6_w", 3, 1);
    word("t6_w", 3, 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 64'(bus.busy), 64'd0);
    check("t6_rst_wx", 64'(bus.writex), 64'd0);
    check("t6_rst_ack", 64'(bus.ack), 64'd0);
    check("t6_rst_gnt", 64'(bus.gnt_id), 64'd0);
    check("t6_rst_cut", 64'(bus.burst_cut), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_regnt", 64'(bus.gnt_id), 64'd3);
    for (int n = 1; n <= MAXBURST; n++) word("t6_w2", 3, n);
    #1;
    check("t6_cut", 64'(bus.burst_cut), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
